countdown_timer: RTL

Loadable down-counter with terminal-count detection: the countdown counterpart of the team's 4-bit up-counter. The timer is loaded with a start value and decrements once per enabled clock. It raises a one-cycle `done` pulse when it reaches zero, then stops, or reloads if reload is compiled in. Other blocks use it for timeouts, delays and periodic ticks.

---
 rtl/countdown_pkg.sv | 12 +
 rtl/countdown_timer.sv | 88 ++++++++
 2 files changed

// File: rtl/countdown_pkg.sv
// Shared types and limits for the countdown timer.
package countdown_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } cd_state_t;

   localparam int CD_WIDTH_MIN = 2;
   localparam int CD_WIDTH_MAX = 16;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle done pulse at terminal count.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload the start value at terminal count and keep running.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             abort,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic [WIDTH-1:0] count_out,
   output logic             busy,
   output logic             done
);

   generate
      if (WIDTH < CD_WIDTH_MIN || WIDTH > CD_WIDTH_MAX) begin : g_bad_width
         $error("countdown_timer: WIDTH out of range");
      end
   endgenerate

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   cd_state_t        state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
      if (abort) begin
         state_d = IDLE;
         count_d = '0;
      end else if (load) begin
         count_d = load_value;
         state_d = (load_value != '0) ? RUN : IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_d = load_value;
`endif
      end else if (state_q == RUN && enable) begin
         // RUN always holds a nonzero count, so <=1 is the terminal case
         if (count_q > ONE) begin
            count_d = count_q - ONE;
         end else begin
            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            count_d = reload_q;
`else
            count_d = '0;
            state_d = IDLE;
`endif
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign count_out = count_q;
   assign busy      = (state_q == RUN);
   assign done      = done_q;

endmodule
